// File: rtl/ks_voice_ctrl.sv
// Single-voice controller: turns MIDI notes into a delay length, drives the karplus_strong engine once per sample tick, and forwards one sample per tick to I2S.
// Optional KS_VOICE_MUTE_EN: a note_off that matches the sounding note silences the voice.
module ks_voice_ctrl #(
  parameter int          TIMEOUT   = 4096,
  parameter logic [10:0] LEN_RESET = 11'd183
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic        note_on,
  input  logic        note_off,
  input  logic [6:0]  note,
  output logic        start,
  output logic        newnote,
  output logic [10:0] length,
  input  logic [23:0] dout,
  input  logic        dout_valid,
  output logic [23:0] sample_out,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [10:0]    pend_len_q, pend_len_d;
  logic           pend_new_q, pend_new_d;
  logic [6:0]     cur_note_q, cur_note_d;
  logic           active_q, active_d;
  logic [10:0]    length_q, length_d;
  logic           newnote_q, newnote_d;
  logic [23:0]    sample_out_q, sample_out_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dv_prev_q;
  logic           overrun_q, overrun_d;
  logic           timeout_err_q, timeout_err_d;

  logic           note_ok;
  logic [10:0]    tbl_len;

  assign note_ok = (note >= 7'd33) && (note <= 7'd108);

  // floor(48000 / f(n)) for the playable range; everything else is rejected by note_ok.
  always_comb begin
    tbl_len = 11'd0;
    case (note)
      7'd33: tbl_len = 11'd872;  7'd34: tbl_len = 11'd823;  7'd35: tbl_len = 11'd777;  7'd36: tbl_len = 11'd733;
      7'd37: tbl_len = 11'd692;  7'd38: tbl_len = 11'd653;  7'd39: tbl_len = 11'd617;  7'd40: tbl_len = 11'd582;
      7'd41: tbl_len = 11'd549;  7'd42: tbl_len = 11'd518;  7'd43: tbl_len = 11'd489;  7'd44: tbl_len = 11'd462;
      7'd45: tbl_len = 11'd436;  7'd46: tbl_len = 11'd411;  7'd47: tbl_len = 11'd388;  7'd48: tbl_len = 11'd366;
      7'd49: tbl_len = 11'd346;  7'd50: tbl_len = 11'd326;  7'd51: tbl_len = 11'd308;  7'd52: tbl_len = 11'd291;
      7'd53: tbl_len = 11'd274;  7'd54: tbl_len = 11'd259;  7'd55: tbl_len = 11'd244;  7'd56: tbl_len = 11'd231;
      7'd57: tbl_len = 11'd218;  7'd58: tbl_len = 11'd205;  7'd59: tbl_len = 11'd194;  7'd60: tbl_len = 11'd183;
      7'd61: tbl_len = 11'd173;  7'd62: tbl_len = 11'd163;  7'd63: tbl_len = 11'd154;  7'd64: tbl_len = 11'd145;
      7'd65: tbl_len = 11'd137;  7'd66: tbl_len = 11'd129;  7'd67: tbl_len = 11'd122;  7'd68: tbl_len = 11'd115;
      7'd69: tbl_len = 11'd109;  7'd70: tbl_len = 11'd102;  7'd71: tbl_len = 11'd97;   7'd72: tbl_len = 11'd91;
      7'd73: tbl_len = 11'd86;   7'd74: tbl_len = 11'd81;   7'd75: tbl_len = 11'd77;   7'd76: tbl_len = 11'd72;
      7'd77: tbl_len = 11'd68;   7'd78: tbl_len = 11'd64;   7'd79: tbl_len = 11'd61;   7'd80: tbl_len = 11'd57;
      7'd81: tbl_len = 11'd54;   7'd82: tbl_len = 11'd51;   7'd83: tbl_len = 11'd48;   7'd84: tbl_len = 11'd45;
      7'd85: tbl_len = 11'd43;   7'd86: tbl_len = 11'd40;   7'd87: tbl_len = 11'd38;   7'd88: tbl_len = 11'd36;
      7'd89: tbl_len = 11'd34;   7'd90: tbl_len = 11'd32;   7'd91: tbl_len = 11'd30;   7'd92: tbl_len = 11'd28;
      7'd93: tbl_len = 11'd27;   7'd94: tbl_len = 11'd25;   7'd95: tbl_len = 11'd24;   7'd96: tbl_len = 11'd22;
      7'd97: tbl_len = 11'd21;   7'd98: tbl_len = 11'd20;   7'd99: tbl_len = 11'd19;   7'd100: tbl_len = 11'd18;
      7'd101: tbl_len = 11'd17;  7'd102: tbl_len = 11'd16;  7'd103: tbl_len = 11'd15;  7'd104: tbl_len = 11'd14;
      7'd105: tbl_len = 11'd13;  7'd106: tbl_len = 11'd12;  7'd107: tbl_len = 11'd12;  7'd108: tbl_len = 11'd11;
      default: tbl_len = 11'd0;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its _q value so no path through this block can infer a latch.
    state_d       = state_q;
    pend_len_d    = pend_len_q;
    pend_new_d    = pend_new_q;
    cur_note_d    = cur_note_q;
    active_d      = active_q;
    length_d      = length_q;
    newnote_d     = 1'b0;
    sample_out_d  = sample_out_q;
    cnt_d         = cnt_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          if (active_q) begin
            // Length and newnote are loaded on entry so both are valid during the start cycle.
            state_d = S_START;
            if (pend_new_q) begin
              newnote_d  = 1'b1;
              length_d   = pend_len_q;
              pend_new_d = 1'b0;
            end
          end else begin
            state_d      = S_OUT;
            sample_out_d = '0;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (dout_valid && !dv_prev_q) begin
          sample_out_d = dout;
          state_d      = S_OUT;
        end else if (cnt_q == CNT_LAST) begin
          sample_out_d  = '0;
          timeout_err_d = 1'b1;
          state_d       = S_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (sample_tick && (state_q != S_IDLE)) overrun_d = 1'b1;

    // Applied after the tick decision so a same-cycle note only affects the following tick.
    if (note_on && note_ok) begin
      pend_len_d = tbl_len;
      pend_new_d = 1'b1;
      cur_note_d = note;
      active_d   = 1'b1;
    end
`ifdef KS_VOICE_MUTE_EN
    else if (note_off && note_ok && (note == cur_note_q)) begin
      active_d = 1'b0;
    end
`endif
  end

`ifndef KS_VOICE_MUTE_EN
  logic unused_note_bits;
  assign unused_note_bits = note_off ^ (^cur_note_q);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pend_len_q    <= LEN_RESET;
      pend_new_q    <= 1'b0;
      cur_note_q    <= '0;
      active_q      <= 1'b0;
      length_q      <= LEN_RESET;
      newnote_q     <= 1'b0;
      sample_out_q  <= '0;
      cnt_q         <= '0;
      dv_prev_q     <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_len_q    <= pend_len_d;
      pend_new_q    <= pend_new_d;
      cur_note_q    <= cur_note_d;
      active_q      <= active_d;
      length_q      <= length_d;
      newnote_q     <= newnote_d;
      sample_out_q  <= sample_out_d;
      cnt_q         <= cnt_d;
      dv_prev_q     <= dout_valid;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign start        = (state_q == S_START);
  assign newnote      = newnote_q;
  assign length       = length_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = (state_q == S_OUT);
  assign busy         = (state_q == S_START) || (state_q == S_WAIT);
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ks_voice_ctrl.sv
// Scoreboard bench for ks_voice_ctrl: a timing-level voice model predicts every sample and engine request; a monitor compares them as the DUT emits.
// Define KS_VOICE_MUTE_EN for both bench and RTL to exercise the mute behaviour.
module tb_ks_voice_ctrl;

  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick, note_on, note_off;
  logic [6:0]  note;
  logic        start, newnote;
  logic [10:0] length;
  logic [23:0] dout;
  logic        dout_valid;
  logic [23:0] sample_out;
  logic        sample_valid, busy, overrun, timeout_err;

  ks_voice_ctrl #(.TIMEOUT(TIMEOUT), .LEN_RESET(11'd183)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .note_on(note_on),
    .note_off(note_off), .note(note), .start(start), .newnote(newnote),
    .length(length), .dout(dout), .dout_valid(dout_valid),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tick;
    int          cycle;
    bit          has_start;
    bit          newnote;
    logic [10:0] len;
    logic [23:0] sample;
    bit          tmo;
    bit          start_seen;
  } exp_t;

  typedef struct {
    int          d;
    logic [23:0] val;
    bit          noresp;
  } plan_t;

  exp_t  q[$];
  plan_t eng_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;

  // Voice model state
  bit          m_active = 0;
  bit          m_pend_new = 0;
  logic [10:0] m_pend_len = 11'd183;
  logic [10:0] m_cur_len = 11'd183;
  logic [6:0]  m_cur_note = 7'd0;
  bit          m_overrun = 0;
  bit          m_tmo = 0;
  int          m_idle_from = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] ref_len(input int n);
    real f;
    f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    return 11'(int'($floor(48000.0 / f)));
  endfunction

  // One cycle of stimulus; the model treats a tick before any same-cycle note event.
  task automatic drive(input bit tick, input bit on, input bit off, input logic [6:0] n,
                       input int d, input logic [23:0] val, input bit noresp);
    int    c;
    bit    valid;
    exp_t  e;
    plan_t p;
    c = cyc;
    valid = (n >= 7'd33) && (n <= 7'd108);
    sample_tick = tick;
    note_on     = on;
    note_off    = off;
    note        = n;
    if (tick) begin
      if (c < m_idle_from) begin
        m_overrun = 1;
      end else begin
        e.tick = c;
        e.start_seen = 0;
        if (m_active) begin
          e.has_start = 1;
          e.newnote = m_pend_new;
          if (m_pend_new) m_cur_len = m_pend_len;
          m_pend_new = 0;
          e.len = m_cur_len;
          if (noresp) begin
            e.sample = '0;
            e.cycle = c + 2 + TIMEOUT;
            m_tmo = 1;
          end else begin
            e.sample = val;
            e.cycle = c + 3 + d;
          end
          p.d = d; p.val = val; p.noresp = noresp;
          eng_q.push_back(p);
        end else begin
          e.has_start = 0;
          e.newnote = 0;
          e.len = m_cur_len;
          e.sample = '0;
          e.cycle = c + 1;
        end
        e.tmo = m_tmo;
        m_idle_from = e.cycle + 1;
        q.push_back(e);
      end
    end
    if (on && valid) begin
      m_pend_len = ref_len(int'(n));
      m_pend_new = 1;
      m_cur_note = n;
      m_active = 1;
    end
`ifdef KS_VOICE_MUTE_EN
    else if (off && valid && n == m_cur_note) begin
      m_active = 0;
    end
`endif
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    note_on     = 1'b0;
    note_off    = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() != 0 || cyc < m_idle_from) && guard < 6000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_within_budget", 64'(guard < 6000), 64'(1));
  endtask

  // Engine model: answers each start after a planned delay with a single-cycle dout_valid pulse.
  initial begin
    plan_t p;
    dout = '0;
    dout_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (start && !rst && eng_q.size() != 0) begin
        p = eng_q.pop_front();
        if (!p.noresp) begin
          repeat (p.d + 1) @(posedge clk);
          #1;
          dout = p.val;
          dout_valid = 1'b1;
          @(posedge clk);
          #1;
          dout_valid = 1'b0;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   exp_busy;
    bit   ok;
    if (!rst) begin
      exp_busy = (q.size() != 0) && q[0].has_start && (cyc > q[0].tick) && (cyc < q[0].cycle);
      check("busy", 64'(busy), 64'(exp_busy));
      if (exp_busy) check("length_stable", 64'(length), 64'(q[0].len));
      check("newnote_only_with_start", 64'(newnote && !start), 64'(0));
      if (start) begin
        ok = (q.size() != 0) && q[0].has_start && !q[0].start_seen;
        check("start_expected", 64'(ok), 64'(1));
        if (ok) begin
          check("start_cycle", 64'(cyc), 64'(q[0].tick + 1));
          check("newnote", 64'(newnote), 64'(q[0].newnote));
          check("length", 64'(length), 64'(q[0].len));
          q[0].start_seen = 1;
        end
      end
      if (sample_valid) begin
        check("sample_valid_expected", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          n_pops++;
          check("sample_out", 64'(sample_out), 64'(e.sample));
          check("sample_cycle", 64'(cyc), 64'(e.cycle));
          check("start_issued", 64'(e.start_seen), 64'(e.has_start));
          check("timeout_err", 64'(timeout_err), 64'(e.tmo));
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_start"}, 64'(start), 64'(0));
    check({tag, "_newnote"}, 64'(newnote), 64'(0));
    check({tag, "_sample_valid"}, 64'(sample_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_overrun"}, 64'(overrun), 64'(0));
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
    check({tag, "_sample_out"}, 64'(sample_out), 64'(0));
    check({tag, "_length"}, 64'(length), 64'(183));
  endtask

  initial begin
    int          pops0;
    bit          tk, on, off;
    logic [6:0]  n;
    int          r;
    rst = 1'b1;
    sample_tick = 1'b0;
    note_on = 1'b0;
    note_off = 1'b0;
    note = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    idle(2);

    // Tick with no note: zero sample one cycle later, no engine request.
    drive(1, 0, 0, 7'd0, 0, 24'h0, 0);
    drain();
    check("len_idle", 64'(length), 64'(183));

    // Note 64, engine answers 0x123456; second tick repeats without newnote.
    drive(0, 1, 0, 7'd64, 0, 24'h0, 0);
    drive(1, 0, 0, 7'd0, 3, 24'h123456, 0);
    drain();
    check("len_after_64", 64'(length), 64'(145));
    drive(1, 0, 0, 7'd0, 5, 24'hfedcba, 0);
    drain();

    // Latest note wins; out-of-range note ignored.
    drive(0, 1, 0, 7'd60, 0, 24'h0, 0);
    drive(0, 1, 0, 7'd67, 0, 24'h0, 0);
    drive(1, 0, 0, 7'd0, 0, 24'h000042, 0);
    drain();
    check("len_latest_note", 64'(length), 64'(122));
    drive(0, 1, 0, 7'd20, 0, 24'h0, 0);
    drive(1, 0, 0, 7'd0, 7, 24'h800001, 0);
    drain();
    check("len_bad_note_ignored", 64'(length), 64'(122));

    // Note-on in the same cycle as an accepted tick lands on the following tick.
    drive(1, 1, 0, 7'd108, 2, 24'h00abcd, 0);
    drain();
    drive(1, 0, 0, 7'd0, 2, 24'h00dcba, 0);
    drain();
    check("len_deferred_note", 64'(length), 64'(11));

    // Engine silent: timeout.
    drive(1, 0, 0, 7'd0, 0, 24'h0, 1);
    drain();
    check("timeout_sticky", 64'(timeout_err), 64'(1));

    // Second tick during WAIT is dropped.
    pops0 = n_pops;
    drive(1, 0, 0, 7'd0, 12, 24'h0a0b0c, 0);
    idle(2);
    drive(1, 0, 0, 7'd0, 0, 24'h0, 0);
    drain();
    check("overrun_sticky", 64'(overrun), 64'(1));
    check("one_sample_for_two_ticks", 64'(n_pops - pops0), 64'(1));

`ifdef KS_VOICE_MUTE_EN
    drive(0, 1, 0, 7'd69, 0, 24'h0, 0);
    drive(0, 0, 1, 7'd69, 0, 24'h0, 0);
    drive(1, 0, 0, 7'd0, 0, 24'h0, 0);
    drain();
    drive(0, 1, 0, 7'd69, 0, 24'h0, 0);
    drive(0, 0, 1, 7'd70, 0, 24'h0, 0);
    drive(1, 0, 0, 7'd0, 4, 24'h135790, 0);
    drain();
    check("len_note_69", 64'(length), 64'(109));
`endif

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      idle(int'($urandom_range(0, 12)));
      r = int'($urandom_range(0, 9));
      on = (r < 4);
      off = (r >= 4) && (r < 6);
      if ($urandom_range(0, 7) == 0) n = 7'($urandom_range(0, 127));
      else n = 7'($urandom_range(33, 108));
      if (off && $urandom_range(0, 1) == 1) n = m_cur_note;
      tk = ($urandom_range(0, 1) == 1);
      drive(tk, on, off, n, int'($urandom_range(0, 15)), 24'($urandom),
            ($urandom_range(0, 79) == 0));
    end
    drain();
    check("overrun_final", 64'(overrun), 64'(m_overrun));
    check("timeout_final", 64'(timeout_err), 64'(m_tmo));

    // Reset in the middle of WAIT; the late engine pulse must be ignored.
    drive(0, 1, 0, 7'd72, 0, 24'h0, 0);
    drive(1, 0, 0, 7'd0, 8, 24'h777777, 0);
    idle(3);
    check("busy_before_reset", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    q.delete();
    m_active = 0; m_pend_new = 0; m_pend_len = 11'd183; m_cur_len = 11'd183;
    m_cur_note = 7'd0; m_overrun = 0; m_tmo = 0; m_idle_from = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(15);
    drive(1, 0, 0, 7'd0, 0, 24'h0, 0);
    drain();
    check("overrun_after_reset", 64'(overrun), 64'(m_overrun));
    check("len_after_reset", 64'(length), 64'(183));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
